key_event_arbiter: RTL and testbench

Arbitrates and paces the four one-cycle button pulses (post-debounce, post-edge-detect) into a single serialized key-event stream for the digital lock. Simultaneous or closely spaced presses are never lost silently. A round-robin grant queues them into a small FIFO, and the FIFO is drained one key at a time. Consecutive issued keys are spaced at least `GAP` cycles apart, and draining pauses while the lock asserts `hold`. The block sits between the edge detectors and the lock's `button` input.

---
 rtl/key_event_arbiter.sv | 126 ++++++++++++
 tb/tb_key_event_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: round-robin queues the four button pulses into a small FIFO and
// issues them one at a time as single-cycle key pulses, spaced by GAP and stalled by hold.
module key_event_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               btn_pulse,
    input  logic                     hold,
    output logic [3:0]               key_out,
    output logic [1:0]               key_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Wide enough to hold GAP-1; at least one bit so GAP=1 still elaborates.
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [3:0]    pend_q, pend_d;
    logic [1:0]    rr_q, rr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    key_out_q, key_out_d;
    logic [1:0]    key_code_q, key_code_d;
    logic [1:0]    mem_q [DEPTH];

    logic [3:0] req;
    logic [1:0] cand;
    logic [1:0] grant_idx;
    logic       grant_hit;
    logic       push;
    logic       pop;
    logic [1:0] head;

    // Round-robin search of the combined request starting at rr.
    always_comb begin
        req       = pend_q | btn_pulse;
        grant_hit = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!grant_hit && req[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Push/pop decisions and next-state for all control registers.
    always_comb begin
        // Registered count only: a same-cycle pop never frees a slot for this write.
        push = grant_hit && (count_q < CW'(DEPTH));
        pop  = (count_q != '0) && !hold && (gap_q == '0);
        head = mem_q[rptr_q];

        pend_d     = push ? (req & ~(4'b0001 << grant_idx)) : req;
        rr_d       = push ? (grant_idx + 2'd1) : rr_q;
        wptr_d     = push ? (wptr_q + AW'(1)) : wptr_q;
        rptr_d     = pop ? (rptr_q + AW'(1)) : rptr_q;
        overflow_d = overflow_q | (|(btn_pulse & pend_q));

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        gap_d = gap_q;
        if (pop) begin
            gap_d = GW'(GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end

        key_out_d  = pop ? (4'b0001 << head) : 4'b0000;
        key_code_d = pop ? head : 2'd0;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            rr_q       <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            key_out_q  <= '0;
            key_code_q <= '0;
        end else begin
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
            key_out_q  <= key_out_d;
            key_code_q <= key_code_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= grant_idx;
        end
    end

    assign key_out    = key_out_q;
    assign key_code   = key_code_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign busy       = (pend_q != '0) || (count_q != '0) || (gap_q != '0);

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with DEPTH=4, GAP=8.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_pulse;
    logic       hold;
    logic [3:0] key_out;
    logic [1:0] key_code;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ev_cyc[$];
    int ev_key[$];
    int ev_code[$];
    int e;

    key_event_arbiter #(.DEPTH(4), .GAP(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_pulse  (btn_pulse),
        .hold       (hold),
        .key_out    (key_out),
        .key_code   (key_code),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count edges and log every issued key pulse with the edge it followed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (key_out != 4'b0000) begin
            ev_cyc.push_back(cyc);
            ev_key.push_back(int'(key_out));
            ev_code.push_back(int'(key_code));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] b);
        btn_pulse = b;
        tick();
        btn_pulse = 4'b0000;
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_key.delete();
        ev_code.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        btn_pulse = 4'b0000;
        hold      = 1'b0;
        ticks(3);
        check("rst_key_out", int'(key_out), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        ticks(2);

        // Single press: count=1 after the press edge, pulse on the next edge only.
        clear_log();
        press(4'b0001);
        e = cyc;
        check("single_count1", int'(fifo_count), 1);
        check("single_nokey", int'(key_out), 0);
        tick();
        check("single_key", int'(key_out), 1);
        check("single_code", int'(key_code), 0);
        check("single_count0", int'(fifo_count), 0);
        tick();
        check("single_onecycle", int'(key_out), 0);
        ticks(5);
        check("single_busy_gap", int'(busy), 1);
        tick();
        check("single_busy_drop", int'(busy), 0);
        check("single_nevents", ev_cyc.size(), 1);
        if (ev_cyc.size() >= 1) check("single_ev_cyc", ev_cyc[0] - e, 1);

        // All four at once from rr=0: issue order 0..3 spaced by 8.
        do_reset();
        ticks(2);
        clear_log();
        press(4'b1111);
        e = cyc;
        ticks(32);
        check("all_nevents", ev_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ev_cyc.size()) begin
                check($sformatf("all_key%0d", i), ev_key[i], 1 << i);
                check($sformatf("all_cyc%0d", i), ev_cyc[i] - e, 1 + 8 * i);
            end
        end
        check("all_overflow", int'(overflow), 0);
        check("all_idle", int'(busy), 0);

        // Round-robin wrap: after key 2, rr=3, so 0101 grants 0 then 2.
        clear_log();
        press(4'b0100);
        ticks(12);
        press(4'b0101);
        ticks(20);
        check("rr_nevents", ev_cyc.size(), 3);
        if (ev_cyc.size() == 3) begin
            check("rr_code0", ev_code[0], 2);
            check("rr_code1", ev_code[1], 0);
            check("rr_code2", ev_code[2], 2);
            check("rr_spacing", ev_cyc[2] - ev_cyc[1], 8);
        end

        // Full FIFO under hold: four queued, two pending, a repeat of key 0 overflows.
        clear_log();
        hold = 1'b1;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        press(4'b0001);
        press(4'b0010);
        tick();
        check("full_count", int'(fifo_count), 4);
        check("full_no_ovf", int'(overflow), 0);
        check("full_held", ev_cyc.size(), 0);
        press(4'b0001);
        check("full_ovf", int'(overflow), 1);
        ticks(3);
        check("full_ovf_sticky", int'(overflow), 1);
        hold = 1'b0;
        e = cyc;
        ticks(50);
        check("full_nevents", ev_cyc.size(), 6);
        if (ev_cyc.size() == 6) begin
            check("full_first_cyc", ev_cyc[0] - e, 1);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("full_code%0d", i), ev_code[i], i % 4);
                if (i > 0) check($sformatf("full_gap%0d", i), ev_cyc[i] - ev_cyc[i-1], 8);
            end
        end
        check("full_ovf_end", int'(overflow), 1);
        check("full_count_end", int'(fifo_count), 0);

        // Hold inside the gap costs nothing.
        do_reset();
        check("hg_ovf_cleared", int'(overflow), 0);
        clear_log();
        press(4'b0011);
        e = cyc;
        for (int k = 1; k <= 20; k++) begin
            hold = (k >= 3 && k <= 5);
            tick();
        end
        hold = 1'b0;
        check("hg_nevents", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) begin
            check("hg_first", ev_cyc[0] - e, 1);
            check("hg_second", ev_cyc[1] - e, 9);
        end

        // Hold across the decision cycle delays by exactly its length (3).
        clear_log();
        press(4'b0011);
        e = cyc;
        for (int k = 1; k <= 20; k++) begin
            hold = (k >= 9 && k <= 11);
            tick();
        end
        hold = 1'b0;
        check("hd_nevents", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) check("hd_second", ev_cyc[1] - e, 12);

        // Reset mid-drain discards everything queued.
        hold = 1'b1;
        press(4'b0111);
        ticks(3);
        check("rd_count3", int'(fifo_count), 3);
        clear_log();
        rst  = 1'b1;
        hold = 1'b0;
        tick();
        rst = 1'b0;
        check("rd_key", int'(key_out), 0);
        check("rd_count", int'(fifo_count), 0);
        check("rd_busy", int'(busy), 0);
        ticks(30);
        check("rd_no_events", ev_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
